// File: rtl/axis_gatekeeper_mc_pkg.sv
// Shared types and helpers for the multi-channel AXI4-Stream credit gate.
package axis_gatekeeper_mc_pkg;

  localparam int GK_MAX_CHANNELS = 16;

  typedef enum logic [0:0] {
    GK_IDLE = 1'b0,
    GK_PKT  = 1'b1
  } gk_state_t;

  function automatic int gk_dest_width(input int num_channels);
    return (num_channels <= 1) ? 1 : $clog2(num_channels);
  endfunction

  // Optional sideband fields keep a one-bit port when disabled.
  function automatic int gk_width_or_one(input int width);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/axis_gk_skid.sv
// Two-entry register slice: output and ready are flop-driven, one spare entry
// absorbs the beat in flight when the consumer stalls.
module axis_gk_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] out_reg;
  logic [W-1:0] skid_reg;
  logic         out_valid_reg;
  logic         skid_valid_reg;
  logic         ready_reg;
  logic         skid_valid_next;
  logic         in_fire;
  logic         load_out;

  assign in_fire  = in_valid && ready_reg;
  assign load_out = out_ready || !out_valid_reg;

  // The spare entry only fills when the output register is blocked.
  assign skid_valid_next = load_out ? 1'b0 : (skid_valid_reg || in_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      if (load_out) begin
        if (skid_valid_reg) begin
          out_reg       <= skid_reg;
          out_valid_reg <= 1'b1;
        end else if (in_fire) begin
          out_reg       <= in_data;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (in_fire) begin
        skid_reg <= in_data;
      end
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= !skid_valid_next;
    end
  end

  assign in_ready  = ready_reg;
  assign out_data  = out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: rtl/axis_gatekeeper_mc.sv
// Multi-channel AXI4-Stream credit gate with registered output.
// Optional sticky overflow flags: define AXIS_GATEKEEPER_MC_OVF_EN.
module axis_gatekeeper_mc
  import axis_gatekeeper_mc_pkg::*;
#(
  parameter int C_AXIS_DATA_BYTES  = 8,
  parameter int C_AXIS_USE_TKEEP   = 0,
  parameter int C_AXIS_TUSER_WIDTH = 0,
  parameter int C_AXIS_USE_TLAST   = 0,
  parameter int C_NUM_CHANNELS     = 4,
  parameter int C_COUNT_WIDTH      = 9
) (
  input  logic                                            aclk,
  input  logic                                            aresetn,
  input  logic [C_AXIS_DATA_BYTES*8-1:0]                  s_axis_tdata,
  input  logic [C_AXIS_DATA_BYTES-1:0]                    s_axis_tkeep,
  input  logic [gk_width_or_one(C_AXIS_TUSER_WIDTH)-1:0]  s_axis_tuser,
  input  logic                                            s_axis_tlast,
  input  logic [gk_dest_width(C_NUM_CHANNELS)-1:0]        s_axis_tdest,
  input  logic                                            s_axis_tvalid,
  output logic                                            s_axis_tready,
  output logic [C_AXIS_DATA_BYTES*8-1:0]                  m_axis_tdata,
  output logic [C_AXIS_DATA_BYTES-1:0]                    m_axis_tkeep,
  output logic [gk_width_or_one(C_AXIS_TUSER_WIDTH)-1:0]  m_axis_tuser,
  output logic [gk_dest_width(C_NUM_CHANNELS)-1:0]        m_axis_tdest,
  output logic                                            m_axis_tlast,
  output logic                                            m_axis_tvalid,
  input  logic                                            m_axis_tready,
  input  logic [C_NUM_CHANNELS-1:0]                       s_allow,
  output logic [C_NUM_CHANNELS*C_COUNT_WIDTH-1:0]         s_allow_count
`ifdef AXIS_GATEKEEPER_MC_OVF_EN
  ,
  output logic [C_NUM_CHANNELS-1:0]                       s_allow_ovf
`endif
);

  localparam int DBITS     = C_AXIS_DATA_BYTES * 8;
  localparam int KW        = C_AXIS_DATA_BYTES;
  localparam int UW        = gk_width_or_one(C_AXIS_TUSER_WIDTH);
  localparam int DW        = gk_dest_width(C_NUM_CHANNELS);
  localparam int CW        = C_COUNT_WIDTH;
  localparam int PW        = DBITS + KW + UW + DW + 1;
  localparam int DEST_SPAN = 1 << DW;

  localparam logic [0:0]    ST_IDLE   = GK_IDLE;
  localparam logic [0:0]    ST_PKT    = GK_PKT;
  localparam logic [CW-1:0] COUNT_MAX = '1;
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  logic [0:0]             state_reg;
  logic [0:0]             state_next;
  logic                   first_beat;
  logic                   eff_last;
  logic                   credit_ok;
  logic                   gate_open;
  logic                   skid_ready;
  logic                   in_fire;
  logic [DEST_SPAN-1:0]   credit_vec;
  logic [C_NUM_CHANNELS-1:0] dec;
  logic [KW-1:0]          keep_in;
  logic [UW-1:0]          user_in;
  logic [PW-1:0]          in_bus;
  logic [PW-1:0]          out_bus;

  // Beat mode treats every beat as a complete packet.
  assign eff_last   = (C_AXIS_USE_TLAST != 0) ? s_axis_tlast : 1'b1;
  assign first_beat = (state_reg == ST_IDLE);
  assign credit_ok  = credit_vec[s_axis_tdest];
  assign gate_open  = !first_beat || credit_ok;

  assign s_axis_tready = skid_ready && gate_open;
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_next = state_reg;
    if (in_fire) begin
      state_next = eff_last ? ST_IDLE : ST_PKT;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Out-of-range tdest codes map to padding slots that never hold credit.
  for (genvar gi = 0; gi < DEST_SPAN; gi++) begin : g_chan
    if (gi < C_NUM_CHANNELS) begin : g_real
      logic [CW-1:0] count_reg;

      assign dec[gi] = in_fire && first_beat && (s_axis_tdest == DW'(gi));

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          count_reg <= '0;
        end else if (s_allow[gi] && !dec[gi]) begin
          if (count_reg != COUNT_MAX) begin
            count_reg <= count_reg + COUNT_ONE;
          end
        end else if (dec[gi] && !s_allow[gi]) begin
          count_reg <= count_reg - COUNT_ONE;
        end
      end

      assign credit_vec[gi]            = (count_reg != '0);
      assign s_allow_count[gi*CW +: CW] = count_reg;

`ifdef AXIS_GATEKEEPER_MC_OVF_EN
      logic ovf_reg;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          ovf_reg <= 1'b0;
        end else if (s_allow[gi] && !dec[gi] && (count_reg == COUNT_MAX)) begin
          ovf_reg <= 1'b1;
        end
      end

      assign s_allow_ovf[gi] = ovf_reg;
`endif
    end else begin : g_pad
      assign credit_vec[gi] = 1'b0;
    end
  end

  assign keep_in = (C_AXIS_USE_TKEEP != 0)   ? s_axis_tkeep : '1;
  assign user_in = (C_AXIS_TUSER_WIDTH > 0)  ? s_axis_tuser : '0;
  assign in_bus  = {s_axis_tdata, keep_in, user_in, s_axis_tdest, eff_last};

  axis_gk_skid #(
    .W(PW)
  ) u_skid (
    .clk      (aclk),
    .rst_n    (aresetn),
    .in_data  (in_bus),
    .in_valid (s_axis_tvalid && gate_open),
    .in_ready (skid_ready),
    .out_data (out_bus),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tdest, m_axis_tlast} = out_bus;

endmodule

// File: tb/tb_axis_gatekeeper_mc.sv
// Directed bench: packet-mode instance (a_*) and beat-mode CW=3 instance (b_*).
module tb_axis_gatekeeper_mc;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Packet-mode instance
  logic [7:0]  a_tdata = '0;
  logic [0:0]  a_tkeep = '0;
  logic [0:0]  a_tuser = '0;
  logic        a_tlast = 1'b0;
  logic [1:0]  a_tdest = '0;
  logic        a_tvalid = 1'b0;
  logic        a_tready;
  logic [7:0]  am_tdata;
  logic [0:0]  am_tkeep;
  logic [0:0]  am_tuser;
  logic [1:0]  am_tdest;
  logic        am_tlast;
  logic        am_tvalid;
  logic        am_tready = 1'b1;
  logic [3:0]  a_allow = '0;
  logic [35:0] a_count;

  // Beat-mode instance
  logic [7:0]  b_tdata = '0;
  logic [0:0]  b_tkeep = '0;
  logic [1:0]  b_tuser = '0;
  logic        b_tlast = 1'b0;
  logic [1:0]  b_tdest = '0;
  logic        b_tvalid = 1'b0;
  logic        b_tready;
  logic [7:0]  bm_tdata;
  logic [0:0]  bm_tkeep;
  logic [1:0]  bm_tuser;
  logic [1:0]  bm_tdest;
  logic        bm_tlast;
  logic        bm_tvalid;
  logic        bm_tready = 1'b1;
  logic [3:0]  b_allow = '0;
  logic [11:0] b_count;

`ifdef AXIS_GATEKEEPER_MC_OVF_EN
  logic [3:0] a_ovf;
  logic [3:0] b_ovf;
`endif

  axis_gatekeeper_mc #(
    .C_AXIS_DATA_BYTES(1), .C_AXIS_USE_TKEEP(0), .C_AXIS_TUSER_WIDTH(0),
    .C_AXIS_USE_TLAST(1), .C_NUM_CHANNELS(4), .C_COUNT_WIDTH(9)
  ) dut_pkt (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tuser(a_tuser),
    .s_axis_tlast(a_tlast), .s_axis_tdest(a_tdest), .s_axis_tvalid(a_tvalid),
    .s_axis_tready(a_tready),
    .m_axis_tdata(am_tdata), .m_axis_tkeep(am_tkeep), .m_axis_tuser(am_tuser),
    .m_axis_tdest(am_tdest), .m_axis_tlast(am_tlast), .m_axis_tvalid(am_tvalid),
    .m_axis_tready(am_tready),
    .s_allow(a_allow), .s_allow_count(a_count)
`ifdef AXIS_GATEKEEPER_MC_OVF_EN
    , .s_allow_ovf(a_ovf)
`endif
  );

  axis_gatekeeper_mc #(
    .C_AXIS_DATA_BYTES(1), .C_AXIS_USE_TKEEP(1), .C_AXIS_TUSER_WIDTH(2),
    .C_AXIS_USE_TLAST(0), .C_NUM_CHANNELS(4), .C_COUNT_WIDTH(3)
  ) dut_beat (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tuser(b_tuser),
    .s_axis_tlast(b_tlast), .s_axis_tdest(b_tdest), .s_axis_tvalid(b_tvalid),
    .s_axis_tready(b_tready),
    .m_axis_tdata(bm_tdata), .m_axis_tkeep(bm_tkeep), .m_axis_tuser(bm_tuser),
    .m_axis_tdest(bm_tdest), .m_axis_tlast(bm_tlast), .m_axis_tvalid(bm_tvalid),
    .m_axis_tready(bm_tready),
    .s_allow(b_allow), .s_allow_count(b_count)
`ifdef AXIS_GATEKEEPER_MC_OVF_EN
    , .s_allow_ovf(b_ovf)
`endif
  );

  // Consumer ready pattern for the packet instance, applied 2 units after each edge.
  logic toggle_en = 1'b0;
  logic hold_en   = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (hold_en) am_tready = 1'b0;
      else if (toggle_en) am_tready = ~am_tready;
      else am_tready = 1'b1;
    end
  end

  // Output scoreboard capture and hold-stability watch.
  logic [15:0] a_q[$];
  int          a_hold_viol = 0;
  logic        a_pend = 1'b0;
  logic [7:0]  a_pdata = '0;

  always @(negedge clk) begin
    if (aresetn && am_tvalid && am_tready)
      a_q.push_back({5'd0, am_tdest, am_tlast, am_tdata});
  end

  always @(negedge clk) begin
    if (!aresetn) begin
      a_pend <= 1'b0;
    end else begin
      if (a_pend && (am_tvalid !== 1'b1 || am_tdata !== a_pdata))
        a_hold_viol <= a_hold_viol + 1;
      a_pend  <= am_tvalid && !am_tready;
      a_pdata <= am_tdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [1:0] d, input logic [7:0] x, input logic l, output int to);
    int n;
    n  = 0;
    to = 0;
    a_tvalid = 1'b1; a_tdest = d; a_tdata = x; a_tlast = l;
    #1;
    while (!a_tready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!a_tready) to = 1;
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
  endtask

  logic [15:0] exp6 [6] = '{16'h0050, 16'h0151, 16'h0260, 16'h0361, 16'h0262, 16'h0363};

  initial begin
    int to;
    int tmo;
    int leaks;
    int bad;

    // Reset and no-credit behaviour
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    a_tvalid = 1'b1; a_tdest = 2'd0; a_tdata = 8'hAA;
    #1;
    check("rst tready", a_tready, 1'b0);
    step(); step();
    check("rst m_tvalid", am_tvalid, 1'b0);
    check("rst counts", a_count[31:0], 32'd0);
    check("rst m_tdata", {am_tkeep, am_tdata}, 9'd0);
    check("rst tready held", a_tready, 1'b0);
    $display("T1 reset / no-credit done");
    a_tvalid = 1'b0;

    // Three credits on ch1, four 5-beat packets
    a_allow = 4'b0010;
    step();
    check("credit latency", a_count[17:9], 9'd1);
    step(); step();
    a_allow = 4'b0000;
    check("ch1 credits", a_count[17:9], 9'd3);
    a_q.delete();
    tmo = 0;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 5; b++) begin
        a_send(2'd1, 8'(p*16 + b), (b == 4), to);
        tmo += to;
        if (p == 0 && b == 0) check("data latency", {am_tvalid, am_tdata}, 9'h100);
        if (p == 2 && b == 0) check("ch1 count at pkt3 start", a_count[17:9], 9'd0);
      end
    end
    check("pkts 1-3 timeout", tmo, 0);
    a_tvalid = 1'b1; a_tdest = 2'd1; a_tdata = 8'h30; a_tlast = 1'b0;
    #1;
    leaks = 0;
    for (int k = 0; k < 5; k++) begin
      if (a_tready) leaks++;
      step();
    end
    check("pkt4 stalls", leaks, 0);
    a_allow = 4'b0010;
    step();
    a_allow = 4'b0000;
    check("pkt4 credit", a_count[17:9], 9'd1);
    check("pkt4 tready", a_tready, 1'b1);
    tmo = 0;
    for (int b = 0; b < 5; b++) begin
      a_send(2'd1, 8'(8'h30 + b), (b == 4), to);
      tmo += to;
    end
    check("pkt4 timeout", tmo, 0);
    step(); step();
    check("pkt beats", a_q.size(), 20);
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (a_q[i] !== {5'd0, 2'd1, (i % 5 == 4), 8'((i / 5) * 16 + (i % 5))}) bad++;
    check("pkt beat order", bad, 0);
    check("ch1 final", a_count[17:9], 9'd0);
    $display("T2 packet credit on ch1 done");

    // One credit on ch2, 8-beat packet under toggling backpressure
    a_q.delete();
    a_allow = 4'b0100;
    step();
    a_allow = 4'b0000;
    toggle_en = 1'b1;
    tmo = 0;
    for (int b = 0; b < 8; b++) begin
      a_send(2'd2, 8'(8'h40 + b), (b == 7), to);
      tmo += to;
      if (b == 0) check("ch2 dec", a_count[26:18], 9'd0);
    end
    toggle_en = 1'b0;
    repeat (6) step();
    check("bp timeout", tmo, 0);
    check("bp beats", a_q.size(), 8);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (a_q[i] !== {5'd0, 2'd2, (i == 7), 8'(8'h40 + i)}) bad++;
    check("bp beat order", bad, 0);
    check("ch2 stays 0", a_count[26:18], 9'd0);
    check("hold stable", a_hold_viol, 0);
    $display("T3 backpressure on ch2 done");

    // Head-of-line blocking: ch0 no credit, ch1 two credits
    a_allow = 4'b0010;
    step(); step();
    a_allow = 4'b0000;
    a_q.delete();
    a_tvalid = 1'b1; a_tdest = 2'd0; a_tdata = 8'h50; a_tlast = 1'b0;
    #1;
    leaks = 0;
    for (int k = 0; k < 4; k++) begin
      if (a_tready) leaks++;
      step();
    end
    check("hol ch0 blocked", leaks, 0);
    check("hol ch1 untouched", a_count[17:9], 9'd2);
    a_allow = 4'b0001;
    step();
    a_allow = 4'b0000;
    tmo = 0;
    for (int i = 0; i < 6; i++) begin
      a_send(exp6[i][10:9], exp6[i][7:0], exp6[i][8], to);
      tmo += to;
    end
    step(); step();
    check("hol timeout", tmo, 0);
    check("hol beats", a_q.size(), 6);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (a_q[i] !== exp6[i]) bad++;
    check("hol order", bad, 0);
    check("hol counts", a_count[17:0], 18'd0);
    $display("T4 head-of-line interleave done");

    // Beat mode: allow held high while streaming on ch0 with count=1
    b_allow = 4'b0001;
    step();
    check("beat ch0 credit", b_count[2:0], 3'd1);
    b_tvalid = 1'b1; b_tdest = 2'd0; b_tlast = 1'b0; b_tkeep = 1'b1;
    leaks = 0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      b_tdata = 8'(8'h80 + k);
      b_tuser = 2'(k);
      #1;
      if (!b_tready) leaks++;
      step();
      if (b_count[2:0] !== 3'd1) bad++;
      check("beat out", {bm_tvalid, bm_tdata}, {1'b1, 8'(8'h80 + k)});
    end
    b_tvalid = 1'b0;
    b_allow = 4'b0000;
    step();
    check("beat stalls", leaks, 0);
    check("beat count steady", bad, 0);
    check("beat count after", b_count[2:0], 3'd1);
    check("beat tlast forced", bm_tlast, 1'b1);
    check("beat sideband", {bm_tkeep, bm_tuser, bm_tdest}, 5'b1_01_00);
    $display("T5 beat mode ch0 done");

    // Saturation at 7 on ch3 (CW=3)
    b_allow = 4'b1000;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 7) begin
        check("sat 7th", b_count[11:9], 3'd7);
`ifdef AXIS_GATEKEEPER_MC_OVF_EN
        check("ovf clear at 7th", b_ovf[3], 1'b0);
`endif
      end
      if (k == 8) begin
        check("sat 8th", b_count[11:9], 3'd7);
`ifdef AXIS_GATEKEEPER_MC_OVF_EN
        check("ovf set at 8th", b_ovf[3], 1'b1);
`endif
      end
    end
    b_allow = 4'b0000;
    step();
    check("sat final", b_count[11:9], 3'd7);
    $display("T6 saturation done");

    // Reset mid-packet with a full skid
    a_allow = 4'b0001;
    step();
    a_allow = 4'b0000;
    hold_en = 1'b1;
    step();
    a_send(2'd0, 8'h70, 1'b0, to);
    a_send(2'd0, 8'h71, 1'b0, to);
    check("pre-rst hold", {am_tvalid, am_tdata}, 9'h170);
    aresetn = 1'b0;
    #1;
    check("mid-rst m_tvalid", {am_tvalid, am_tdata}, 9'h000);
    check("mid-rst tready", a_tready, 1'b0);
    check("mid-rst count", a_count[8:0], 9'd0);
    step();
    aresetn = 1'b1;
    hold_en = 1'b0;
    a_allow = 4'b0001;
    step();
    a_allow = 4'b0000;
    a_q.delete();
    a_send(2'd0, 8'h72, 1'b1, to);
    check("post-rst timeout", to, 0);
    check("post-rst first beat dec", a_count[8:0], 9'd0);
    step(); step();
    check("post-rst beats", a_q.size(), 1);
    check("post-rst beat", a_q[0], 16'h0172);
    $display("T7 reset mid-packet done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
